iob_gpio_disp: RTL and testbench
================================

// Module: iob_gpio_disp
// PURPOSE
//  4-digit multiplexed seven-segment display driver for the GPIO peripheral.
//  Accepts a 16-bit value over a valid/ready handshake, for example the GPIO
//  running-max result zero-extended. Scans the value as four hex digits onto
//  the gpio_disp_an/gpio_disp_ca pins.
//  Updates are deferred to a frame boundary to prevent tearing. A blanking
//  interval between digits suppresses ghosting.
// PARAMETERS
//  DIV    100000  cycles per digit slot; must be >= 2
//  BLANK  1000    cycles at the start of each slot with all anodes off; 0 <= BLANK < DIV
// PORTS
//  clk       in   1   clock
//  rst       in   1   asynchronous reset, active-low
//  en        in   1   1 = scan display; 0 = all digits off
//  lz_blank  in   1   1 = suppress leading zero digits
//  in_valid  in   1   new value offered
//  in_ready  out  1   driver can accept a value
//  in_data   in   16  value, digit k = in_data[4k+3:4k]
//  in_dp     in   4   decimal point per digit, 1 = lit
//  disp_an   out  4   anodes, active-low, one-hot-low when lit
//  disp_ca   out  8   cathodes, active-low, {dp,g,f,e,d,c,b,a}
//  frame     out  1   1-cycle pulse at each frame boundary
// BEHAVIOUR
//  Reset (rst=0, async):
//   - disp_an=4'hF, disp_ca=8'hFF, frame=0, in_ready=1.
//   - Pending value discarded. shown value=0, shown dp=0, cnt=0, idx=0.
//  Scan counters:
//   - cnt runs 0..DIV-1, then wraps to 0 and idx increments (3 wraps to 0).
//   - Counters run only when en=1. en=0 holds cnt=0 and idx=0.
//  Slot output:
//   - cnt < BLANK: disp_an=4'hF.
//   - Otherwise: disp_an[idx]=0, all other anodes 1.
//   - disp_an and disp_ca are registered: 1 cycle of latency from (cnt, idx).
//  Frame boundary:
//   - The cycle in which idx=3 and cnt=DIV-1 (en=1).
//   - frame=1 on the following cycle.
//  Hex decode (ca[6:0]):
//   - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
//   - 8=00 9=10 A=08 B=03 C=46 D=21 E=06 F=0E
//   - ca[7] = ~dp[idx].
//  Leading-zero blanking (lz_blank=1):
//   - Digit k>0 is blanked (disp_an[k]=1 for its whole slot) if all digits >= k are 0.
//   - Digit 0 is always shown. lz_blank is sampled combinationally each slot.
//  Handshake:
//   - in_ready = ~pending.
//   - When in_valid & in_ready: pending<=1; pending value <= in_data and in_dp.
//   - in_data is ignored when in_ready=0. The source must hold in_valid until in_ready.
//  Commit:
//   - en=1: at a frame boundary with pending=1, the shown value <= pending value
//     and pending<=0. The new value appears from digit 0 of the next frame.
//   - en=0: pending commits on the cycle after acceptance (display is dark).
//   - Accept and commit never coincide: ready=0 while pending.
//   - in_ready rises the cycle after commit.
//  en falling mid-slot: on the next cycle disp_an=4'hF; cnt and idx reset to 0.
//  en rising: starts at idx=0, cnt=0, including the full BLANK interval.
//  Frame period = 4*DIV cycles. Duty per digit = (DIV-BLANK)/(4*DIV).
// TESTING (DIV=8, BLANK=2)
//  - Reset: rst=0 with en=1 -> disp_an=F, disp_ca=FF, in_ready=1. Release rst,
//    lz_blank=0 -> each slot: 2 cycles an=F, then 6 cycles an one-hot-low with ca=C0.
//  - Load 0x1234, dp=0 -> in_ready=0 until the boundary, then 1. Next frame shows
//    digit0 ca=99, d1=B0, d2=A4, d3=F9.
//  - Two back-to-back loads 0xAAAA then 0x5555 mid-frame -> 0x5555 stalls
//    (in_ready=0). Frame N+1 shows only A (ca=88); 0x5555 (ca=92) from frame N+2.
//  - lz_blank=1, value 0x0005 -> digits 3..1 anodes stay 1; digit0 ca=92.
//    Value 0x0000 -> digit0 ca=C0.
//  - en=0 -> disp_an=F within 1 cycle. Load 0xBEEF -> committed next cycle.
//    en=1 -> first frame shows F,E,E,B (ca=8E,86,86,83).
//  - Assert rst mid-slot with a pending value -> outputs off immediately.
//    After release: value 0 shown, in_ready=1.

Source files
------------

// File: rtl/iob_gpio_disp.sv
`default_nettype none
// ============================================================================
// iob_gpio_disp : 4-digit multiplexed seven-segment hex display driver
// Rev 1.0
// ============================================================================
module iob_gpio_disp #(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_lz_blank,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [15:0] i_in_data,
    input  logic [3:0]  i_in_dp,
    output logic [3:0]  o_disp_an,
    output logic [7:0]  o_disp_ca,
    output logic        o_frame
);

    localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] C_BLANK   = CW'(BLANK);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic          r_pending;
    logic [15:0]   r_pend_val;
    logic [3:0]    r_pend_dp;
    logic [15:0]   r_shown_val;
    logic [3:0]    r_shown_dp;
    logic [3:0]    r_an;
    logic [7:0]    r_ca;
    logic          r_frame;

    logic [3:0]    w_digit;
    logic [6:0]    w_seg;
    logic          w_lz_hide;
    logic          w_boundary;
    logic          w_accept;
    logic          w_commit;

    always_comb begin
        w_digit    = r_shown_val[{r_idx, 2'b00} +: 4];
        w_boundary = i_en && (r_idx == 2'd3) && (r_cnt == C_CNT_MAX);
        w_accept   = i_in_valid && !r_pending;
        // With the scan stopped there is no tearing to avoid, so commit at once.
        w_commit   = r_pending && (w_boundary || !i_en);

        w_lz_hide = 1'b0;
        case (r_idx)
            2'd1:    w_lz_hide = i_lz_blank && (r_shown_val[15:4]  == 12'h000);
            2'd2:    w_lz_hide = i_lz_blank && (r_shown_val[15:8]  == 8'h00);
            2'd3:    w_lz_hide = i_lz_blank && (r_shown_val[15:12] == 4'h0);
            default: w_lz_hide = 1'b0;
        endcase

        w_seg = 7'h7F;
        case (w_digit)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            4'hF: w_seg = 7'h0E;
            default: w_seg = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (r_cnt == C_CNT_MAX) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending   <= 1'b0;
            r_pend_val  <= 16'h0000;
            r_pend_dp   <= 4'h0;
            r_shown_val <= 16'h0000;
            r_shown_dp  <= 4'h0;
        end else if (w_commit) begin
            r_shown_val <= r_pend_val;
            r_shown_dp  <= r_pend_dp;
            r_pending   <= 1'b0;
        end else if (w_accept) begin
            r_pend_val  <= i_in_data;
            r_pend_dp   <= i_in_dp;
            r_pending   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an    <= 4'hF;
            r_ca    <= 8'hFF;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_boundary;
            if (!i_en) begin
                r_an <= 4'hF;
                r_ca <= 8'hFF;
            end else begin
                r_ca <= {~r_shown_dp[r_idx], w_seg};
                if ((r_cnt < C_BLANK) || w_lz_hide) begin
                    r_an <= 4'hF;
                end else begin
                    r_an <= ~(4'b0001 << r_idx);
                end
            end
        end
    end

    assign o_in_ready = ~r_pending;
    assign o_disp_an  = r_an;
    assign o_disp_ca  = r_ca;
    assign o_frame    = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_iob_gpio_disp.sv
`default_nettype none
// ============================================================================
// tb_iob_gpio_disp : randomized bench with a frame-position reference model
// Rev 1.0
// ============================================================================
module tb_iob_gpio_disp;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FR    = 4 * DIV;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        en       = 1'b1;
    logic        lz       = 1'b0;
    logic        valid    = 1'b0;
    logic [15:0] data     = 16'h0000;
    logic [3:0]  dp       = 4'h0;
    logic        o_in_ready;
    logic [3:0]  o_disp_an;
    logic [7:0]  o_disp_ca;
    logic        o_frame;

    int checks = 0;
    int errors = 0;

    iob_gpio_disp #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (en),
        .i_lz_blank (lz),
        .i_in_valid (valid),
        .o_in_ready (o_in_ready),
        .i_in_data  (data),
        .i_in_dp    (dp),
        .o_disp_an  (o_disp_an),
        .o_disp_ca  (o_disp_ca),
        .o_frame    (o_frame)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event at %0t", name, $time);
    endtask

    // Reference model: p is the position within the frame since the scan started.
    int          p       = 0;
    logic [15:0] m_val   = 16'h0000;
    logic [3:0]  m_dp    = 4'h0;
    logic [15:0] m_pval  = 16'h0000;
    logic [3:0]  m_pdp   = 4'h0;
    bit          m_pend  = 1'b0;
    logic [3:0]  e_an    = 4'hF;
    logic [7:0]  e_ca    = 8'hFF;
    bit          e_frame = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p = 0; m_val = 16'h0; m_dp = 4'h0; m_pend = 1'b0;
            e_an = 4'hF; e_ca = 8'hFF; e_frame = 1'b0;
        end else begin
            int c, k;
            bit lit, bnd, acc, com;
            c = p % DIV;
            k = p / DIV;
            if (!en) begin
                e_an = 4'hF;
                e_ca = 8'hFF;
            end else begin
                lit  = (c >= BLANK) && !(lz && k > 0 && (m_val >> (4 * k)) == 16'h0);
                e_an = lit ? ~(4'b0001 << k) : 4'hF;
                e_ca = {~m_dp[k], seg(m_val[4 * k +: 4])};
            end
            bnd     = en && (p == FR - 1);
            e_frame = bnd;
            acc     = valid && !m_pend;
            com     = m_pend && (!en || bnd);
            if (com) begin
                m_val = m_pval; m_dp = m_pdp; m_pend = 1'b0;
            end else if (acc) begin
                m_pval = data; m_pdp = dp; m_pend = 1'b1;
            end
            p = en ? (p + 1) % FR : 0;
        end
    end

    initial begin
        #1;
        forever begin
            @(posedge clk);
            #2;
            chk("an", o_disp_an, e_an);
            chk("frame", o_frame, e_frame);
            chk("ready", o_in_ready, !m_pend);
            if (e_an != 4'hF) chk("ca", o_disp_ca, e_ca);
        end
    end

    task automatic send(input logic [15:0] v, input logic [3:0] d);
        int n;
        @(negedge clk);
        valid = 1'b1; data = v; dp = d;
        n = 0;
        while (!o_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout_fail("send_ready");
        @(negedge clk);
        valid = 1'b0;
        data  = 16'($urandom);
        dp    = 4'($urandom);
    endtask

    task automatic expect_digit(input string name, input int k, input logic [7:0] ca);
        int n;
        n = 0;
        while (o_disp_an !== ~(4'b0001 << k) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout_fail(name);
        else chk(name, o_disp_ca, ca);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (o_frame !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout_fail("frame_wait");
    endtask

    initial begin
        int hidden;
        repeat (3) @(negedge clk);
        chk("rst_an", o_disp_an, 4'hF);
        chk("rst_ca", o_disp_ca, 8'hFF);
        chk("rst_ready", o_in_ready, 1'b1);
        chk("rst_frame", o_frame, 1'b0);
        rst_n = 1'b1;
        expect_digit("zero_d0", 0, 8'hC0);
        expect_digit("zero_d3", 3, 8'hC0);

        send(16'h1234, 4'h0);
        chk("load_ready_low", o_in_ready, 1'b0);
        wait_frame();
        chk("commit_ready_high", o_in_ready, 1'b1);
        expect_digit("v1234_d0", 0, 8'h99);
        expect_digit("v1234_d1", 1, 8'hB0);
        expect_digit("v1234_d2", 2, 8'hA4);
        expect_digit("v1234_d3", 3, 8'hF9);

        send(16'hAAAA, 4'h0);
        send(16'h5555, 4'h0);
        for (int k = 0; k < 4; k++) expect_digit("vAAAA", k, 8'h88);
        for (int k = 0; k < 4; k++) expect_digit("v5555", k, 8'h92);

        lz = 1'b1;
        send(16'h0005, 4'h0);
        wait_frame();
        hidden = 0;
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            if (o_disp_an[3:1] != 3'b111) hidden++;
        end
        chk("lz_upper_dark", hidden, 0);
        expect_digit("lz_d0", 0, 8'h92);
        send(16'h0000, 4'h0);
        wait_frame();
        expect_digit("lz_zero_d0", 0, 8'hC0);
        lz = 1'b0;

        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en_off_an", o_disp_an, 4'hF);
        send(16'hBEEF, 4'h0);
        chk("en_off_pending", o_in_ready, 1'b0);
        @(negedge clk);
        chk("en_off_committed", o_in_ready, 1'b1);
        en = 1'b1;
        expect_digit("vBEEF_d0", 0, 8'h8E);
        expect_digit("vBEEF_d1", 1, 8'h86);
        expect_digit("vBEEF_d2", 2, 8'h86);
        expect_digit("vBEEF_d3", 3, 8'h83);

        send(16'h7777, 4'hF);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_an", o_disp_an, 4'hF);
        chk("midrst_ca", o_disp_ca, 8'hFF);
        chk("midrst_ready", o_in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) expect_digit("midrst_zero", k, 8'hC0);

        for (int i = 0; i < 80; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 4) begin
                send(16'($urandom), 4'($urandom));
            end else if (op < 6) begin
                @(negedge clk);
                en = ~en;
            end else if (op == 6) begin
                @(negedge clk);
                lz = 1'($urandom);
            end else begin
                repeat ($urandom_range(0, 40)) @(negedge clk);
            end
        end
        repeat (FR) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
